// File: rtl/sja1000_bus_seq_pkg.sv
// Shared state encoding and default bus timing for the SJA1000 Intel-mode
// multiplexed bus sequencer.
package sja1000_bus_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ALE     = 3'd1,
    S_AHOLD   = 3'd2,
    S_TURN    = 3'd3,
    S_STROBE  = 3'd4,
    S_HOLD    = 3'd5,
    S_RECOVER = 3'd6
  } state_t;

  localparam int unsigned T_ALE_DEF     = 2;
  localparam int unsigned T_SETUP_DEF   = 1;
  localparam int unsigned T_STROBE_DEF  = 4;
  localparam int unsigned T_HOLD_DEF    = 1;
  localparam int unsigned T_RECOVER_DEF = 2;
  localparam int unsigned U_DLY_DEF     = 1;

  // Down-counter load value for a phase of t cycles; 0 is treated as 1 and
  // anything beyond the 4-bit range saturates at 16 cycles.
  function automatic logic [3:0] phase_load(input int unsigned t);
    if (t == 0)
      return 4'd0;
    else if (t > 16)
      return 4'd15;
    else
      return 4'(t - 1);
  endfunction

endpackage

// File: rtl/sja1000_bus_seq.sv
// Sequences one Intel-mode multiplexed SJA1000 register access per request:
// ALE address phase, optional read turnaround, WRn/RDn strobe, hold, recovery.
module sja1000_bus_seq
  import sja1000_bus_seq_pkg::*;
#(
  parameter int unsigned T_ALE     = T_ALE_DEF,
  parameter int unsigned T_SETUP   = T_SETUP_DEF,
  parameter int unsigned T_STROBE  = T_STROBE_DEF,
  parameter int unsigned T_HOLD    = T_HOLD_DEF,
  parameter int unsigned T_RECOVER = T_RECOVER_DEF,
  parameter int unsigned U_DLY     = U_DLY_DEF
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       req_wr,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sja1000_csn,
  output logic       sja1000_ale,
  output logic       sja1000_wrn,
  output logic       sja1000_rdn,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in
);

  if (T_STROBE > 15) begin : g_strobe_range
    $error("T_STROBE exceeds the 4-bit phase counter");
  end
  if (U_DLY > 1000) begin : g_udly_range
    $error("U_DLY out of range");
  end

  localparam logic [3:0] LD_ALE     = phase_load(T_ALE);
  localparam logic [3:0] LD_SETUP   = phase_load(T_SETUP);
  localparam logic [3:0] LD_STROBE  = phase_load(T_STROBE);
  localparam logic [3:0] LD_HOLD    = phase_load(T_HOLD);
  localparam logic [3:0] LD_RECOVER = phase_load(T_RECOVER);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_wr, w_wr_nxt;
  logic [7:0] r_addr, w_addr_nxt;
  logic [7:0] r_wdata, w_wdata_nxt;
  logic [7:0] r_ad_in_q;
  logic [7:0] r_rdata;

  logic       r_csn, r_ale, r_wrn, r_rdn, r_oe, r_busy, r_done;
  logic [7:0] r_ad_out;
  logic       w_csn, w_ale, w_wrn, w_rdn, w_oe, w_busy, w_done;
  logic [7:0] w_ad_out;

  logic       w_accept;
  logic       w_phase_end;

  assign w_accept    = (r_state == S_IDLE) && req;
  assign w_phase_end = (r_cnt == 4'd0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (req) begin
          w_state_nxt = S_ALE;
          w_cnt_nxt   = LD_ALE;
        end
      end
      S_ALE: begin
        if (w_phase_end) begin
          w_state_nxt = S_AHOLD;
          w_cnt_nxt   = LD_SETUP;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_AHOLD: begin
        if (w_phase_end) begin
          w_state_nxt = r_wr ? S_STROBE : S_TURN;
          w_cnt_nxt   = r_wr ? LD_STROBE : 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_TURN: begin
        w_state_nxt = S_STROBE;
        w_cnt_nxt   = LD_STROBE;
      end
      S_STROBE: begin
        if (w_phase_end) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = LD_HOLD;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_HOLD: begin
        if (w_phase_end) begin
          w_state_nxt = S_RECOVER;
          w_cnt_nxt   = LD_RECOVER;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_RECOVER: begin
        if (w_phase_end) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign w_wr_nxt    = w_accept ? req_wr    : r_wr;
  assign w_addr_nxt  = w_accept ? req_addr  : r_addr;
  assign w_wdata_nxt = w_accept ? req_wdata : r_wdata;

  // Outputs are decoded from the next state so the registered pins line up
  // with the state they belong to, without any combinational path to a port.
  always_comb begin
    w_csn    = 1'b1;
    w_ale    = 1'b0;
    w_wrn    = 1'b1;
    w_rdn    = 1'b1;
    w_oe     = 1'b0;
    w_ad_out = 8'h00;
    unique case (w_state_nxt)
      S_ALE: begin
        w_ale    = 1'b1;
        w_oe     = 1'b1;
        w_ad_out = w_addr_nxt;
      end
      S_AHOLD: begin
        w_oe     = 1'b1;
        w_ad_out = w_addr_nxt;
      end
      S_TURN: begin
        w_csn = 1'b0;
      end
      S_STROBE: begin
        w_csn = 1'b0;
        if (w_wr_nxt) begin
          w_wrn    = 1'b0;
          w_oe     = 1'b1;
          w_ad_out = w_wdata_nxt;
        end else begin
          w_rdn = 1'b0;
        end
      end
      S_HOLD: begin
        w_csn = 1'b0;
        if (w_wr_nxt) begin
          w_oe     = 1'b1;
          w_ad_out = w_wdata_nxt;
        end
      end
      default: ;
    endcase
  end

  assign w_busy = (w_state_nxt != S_IDLE);
  assign w_done = (r_state != S_IDLE) && (w_state_nxt == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_ad_in_q <= '0;
      r_rdata   <= '0;
      r_csn     <= 1'b1;
      r_ale     <= 1'b0;
      r_wrn     <= 1'b1;
      r_rdn     <= 1'b1;
      r_oe      <= 1'b0;
      r_ad_out  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_wr      <= w_wr_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_ad_in_q <= ad_in;
      if ((r_state == S_STROBE) && !r_wr && w_phase_end)
        r_rdata <= r_ad_in_q;
      r_csn     <= w_csn;
      r_ale     <= w_ale;
      r_wrn     <= w_wrn;
      r_rdn     <= w_rdn;
      r_oe      <= w_oe;
      r_ad_out  <= w_ad_out;
      r_busy    <= w_busy;
      r_done    <= w_done;
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign rdata       = r_rdata;
  assign sja1000_csn = r_csn;
  assign sja1000_ale = r_ale;
  assign sja1000_wrn = r_wrn;
  assign sja1000_rdn = r_rdn;
  assign ad_oe       = r_oe;
  assign ad_out      = r_ad_out;

endmodule

// File: tb/tb_sja1000_bus_seq.sv
// Directed bench: per-cycle pin traces of each access are packed into bit
// masks (bit k = cycle k after the accept edge) and compared to hand values.
module tb_sja1000_bus_seq;

  logic       clk;
  logic       rst_n;
  logic       req;
  logic       req_wr;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic [7:0] rd_data;
  int unsigned sel;

  logic       req0, req1, req2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;
  logic [7:0] rdata0, rdata1, rdata2;
  logic       csn0, csn1, csn2;
  logic       ale0, ale1, ale2;
  logic       wrn0, wrn1, wrn2;
  logic       rdn0, rdn1, rdn2;
  logic [7:0] ado0, ado1, ado2;
  logic       oe0, oe1, oe2;
  logic [7:0] adi0, adi1, adi2;

  int n_checks;
  int n_fail;
  int n_viol;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign req0 = req && (sel == 0);
  assign req1 = req && (sel == 1);
  assign req2 = req && (sel == 2);

  // Peripheral model: drives the read byte only while RDn is low.
  assign adi0 = rdn0 ? 8'h00 : rd_data;
  assign adi1 = rdn1 ? 8'h00 : rd_data;
  assign adi2 = rdn2 ? 8'h00 : rd_data;

  sja1000_bus_seq u_dut (
    .clk(clk), .rst_n(rst_n), .req(req0), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy0), .done(done0), .rdata(rdata0),
    .sja1000_csn(csn0), .sja1000_ale(ale0), .sja1000_wrn(wrn0), .sja1000_rdn(rdn0),
    .ad_out(ado0), .ad_oe(oe0), .ad_in(adi0)
  );

  sja1000_bus_seq #(.T_STROBE(0)) u_dut_s0 (
    .clk(clk), .rst_n(rst_n), .req(req1), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy1), .done(done1), .rdata(rdata1),
    .sja1000_csn(csn1), .sja1000_ale(ale1), .sja1000_wrn(wrn1), .sja1000_rdn(rdn1),
    .ad_out(ado1), .ad_oe(oe1), .ad_in(adi1)
  );

  sja1000_bus_seq #(.T_STROBE(15)) u_dut_s15 (
    .clk(clk), .rst_n(rst_n), .req(req2), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy2), .done(done2), .rdata(rdata2),
    .sja1000_csn(csn2), .sja1000_ale(ale2), .sja1000_wrn(wrn2), .sja1000_rdn(rdn2),
    .ad_out(ado2), .ad_oe(oe2), .ad_in(adi2)
  );

  logic       m_busy, m_done, m_csn, m_ale, m_wrn, m_rdn, m_oe;
  logic [7:0] m_rdata, m_ado;

  always_comb begin
    m_busy = busy0; m_done = done0; m_csn = csn0; m_ale = ale0;
    m_wrn = wrn0; m_rdn = rdn0; m_oe = oe0; m_rdata = rdata0; m_ado = ado0;
    if (sel == 1) begin
      m_busy = busy1; m_done = done1; m_csn = csn1; m_ale = ale1;
      m_wrn = wrn1; m_rdn = rdn1; m_oe = oe1; m_rdata = rdata1; m_ado = ado1;
    end else if (sel == 2) begin
      m_busy = busy2; m_done = done2; m_csn = csn2; m_ale = ale2;
      m_wrn = wrn2; m_rdn = rdn2; m_oe = oe2; m_rdata = rdata2; m_ado = ado2;
    end
  end

  a_oe_rdn0: assert property (@(posedge clk) !(oe0 && !rdn0));
  a_oe_rdn1: assert property (@(posedge clk) !(oe1 && !rdn1));
  a_oe_rdn2: assert property (@(posedge clk) !(oe2 && !rdn2));

  always @(negedge clk) begin
    if ((oe0 && !rdn0) || (oe1 && !rdn1) || (oe2 && !rdn2))
      n_viol = n_viol + 1;
  end

  logic [31:0] mk_ale, mk_wrn, mk_rdn, mk_csn, mk_oe, mk_done, mk_busy;
  logic [7:0]  ad_at [0:31];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Issues one request and records 28 cycles of pins; optionally pulses a
  // second request during cycle inj_at.
  task automatic run_access(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                            input int unsigned inj_at, input logic inj_wr,
                            input logic [7:0] inj_addr);
    mk_ale = '0; mk_wrn = '0; mk_rdn = '0; mk_csn = '0;
    mk_oe = '0; mk_done = '0; mk_busy = '0;
    for (int unsigned i = 0; i < 32; i++) ad_at[i] = 8'h00;
    @(negedge clk);
    req = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
    for (int unsigned k = 1; k <= 28; k++) begin
      @(negedge clk);
      mk_ale[k]  = m_ale;
      mk_wrn[k]  = ~m_wrn;
      mk_rdn[k]  = ~m_rdn;
      mk_csn[k]  = ~m_csn;
      mk_oe[k]   = m_oe;
      mk_done[k] = m_done;
      mk_busy[k] = m_busy;
      ad_at[k]   = m_ado;
      req = 1'b0;
      if (k == inj_at) begin
        req = 1'b1; req_wr = inj_wr; req_addr = inj_addr; req_wdata = 8'h3C;
      end
    end
    req = 1'b0;
  endtask

  int unsigned n_done_seen;

  initial begin
    n_checks = 0; n_fail = 0; n_viol = 0;
    sel = 0; req = 1'b0; req_wr = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    rd_data = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_csn",   {31'd0, m_csn},  32'd1);
    chk("rst_ale",   {31'd0, m_ale},  32'd0);
    chk("rst_wrn_rdn", {30'd0, m_wrn, m_rdn}, 32'd3);
    chk("rst_oe",    {31'd0, m_oe},   32'd0);
    chk("rst_ad",    {24'd0, m_ado},  32'h00);
    chk("rst_rdata", {24'd0, m_rdata}, 32'h00);
    chk("rst_busy_done", {30'd0, m_busy, m_done}, 32'd0);

    // Write 0x12 <- 0xA5
    run_access(1'b1, 8'h12, 8'hA5, 0, 1'b0, 8'h00);
    chk("wr_ale",  mk_ale,  32'h0000_0006);
    chk("wr_wrn",  mk_wrn,  32'h0000_00F0);
    chk("wr_rdn",  mk_rdn,  32'h0000_0000);
    chk("wr_csn",  mk_csn,  32'h0000_01F0);
    chk("wr_oe",   mk_oe,   32'h0000_01FE);
    chk("wr_done", mk_done, 32'h0000_0800);
    chk("wr_busy", mk_busy, 32'h0000_07FE);
    chk("wr_ad_c1", {24'd0, ad_at[1]}, 32'h12);
    chk("wr_ad_c3", {24'd0, ad_at[3]}, 32'h12);
    chk("wr_ad_c4", {24'd0, ad_at[4]}, 32'hA5);
    chk("wr_ad_c8", {24'd0, ad_at[8]}, 32'hA5);
    chk("wr_rdata_kept", {24'd0, m_rdata}, 32'h00);

    // Read 0x03, peripheral returns 0x5C
    rd_data = 8'h5C;
    run_access(1'b0, 8'h03, 8'h00, 0, 1'b0, 8'h00);
    chk("rd_ale",  mk_ale,  32'h0000_0006);
    chk("rd_ad_c1", {24'd0, ad_at[1]}, 32'h03);
    chk("rd_oe",   mk_oe,   32'h0000_000E);
    chk("rd_csn",  mk_csn,  32'h0000_03F0);
    chk("rd_rdn",  mk_rdn,  32'h0000_01E0);
    chk("rd_wrn",  mk_wrn,  32'h0000_0000);
    chk("rd_done", mk_done, 32'h0000_1000);
    chk("rd_busy", mk_busy, 32'h0000_0FFE);
    chk("rd_rdata", {24'd0, m_rdata}, 32'h5C);

    // Request during a busy write is dropped
    rd_data = 8'hEE;
    run_access(1'b1, 8'h21, 8'h4B, 6, 1'b1, 8'h77);
    chk("ign_ale",  mk_ale,  32'h0000_0006);
    chk("ign_wrn",  mk_wrn,  32'h0000_00F0);
    chk("ign_done", mk_done, 32'h0000_0800);
    chk("ign_rdata_kept", {24'd0, m_rdata}, 32'h5C);

    // Read requested in the done cycle of a write
    rd_data = 8'h96;
    run_access(1'b1, 8'h30, 8'h11, 11, 1'b0, 8'h31);
    chk("b2b_ale",  mk_ale,  32'h0000_3006);
    chk("b2b_wrn",  mk_wrn,  32'h0000_00F0);
    chk("b2b_rdn",  mk_rdn,  32'h000F_0000);
    chk("b2b_done", mk_done, 32'h0080_0800);
    chk("b2b_busy", mk_busy, 32'h007F_F7FE);
    chk("b2b_ad_c12", {24'd0, ad_at[12]}, 32'h31);
    chk("b2b_rdata", {24'd0, m_rdata}, 32'h96);

    // Reset asserted during STROBE of a write
    @(negedge clk);
    req = 1'b1; req_wr = 1'b1; req_addr = 8'h12; req_wdata = 8'hA5;
    @(negedge clk);
    req = 1'b0;
    repeat (4) @(negedge clk);
    chk("mrst_in_strobe", {31'd0, m_wrn}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mrst_csn", {31'd0, m_csn}, 32'd1);
    chk("mrst_wrn_rdn", {30'd0, m_wrn, m_rdn}, 32'd3);
    chk("mrst_oe", {31'd0, m_oe}, 32'd0);
    chk("mrst_busy", {31'd0, m_busy}, 32'd0);
    n_done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (m_done) n_done_seen++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (m_done) n_done_seen++;
    end
    chk("mrst_no_done", n_done_seen, 32'd0);
    chk("mrst_rdata", {24'd0, m_rdata}, 32'h00);
    run_access(1'b1, 8'h12, 8'hA5, 0, 1'b0, 8'h00);
    chk("post_rst_ale",  mk_ale,  32'h0000_0006);
    chk("post_rst_wrn",  mk_wrn,  32'h0000_00F0);
    chk("post_rst_done", mk_done, 32'h0000_0800);

    // T_STROBE=0 behaves as a single strobe cycle
    sel = 1;
    run_access(1'b1, 8'h44, 8'h5A, 0, 1'b0, 8'h00);
    chk("s0_wrn",  mk_wrn,  32'h0000_0010);
    chk("s0_done", mk_done, 32'h0000_0100);
    chk("s0_ad_c4", {24'd0, ad_at[4]}, 32'h5A);

    // T_STROBE=15 read
    sel = 2;
    rd_data = 8'hC3;
    run_access(1'b0, 8'h40, 8'h00, 0, 1'b0, 8'h00);
    chk("s15_rdn",  mk_rdn,  32'h000F_FFE0);
    chk("s15_done", mk_done, 32'h0080_0000);
    chk("s15_rdata", {24'd0, m_rdata}, 32'hC3);

    sel = 0;
    repeat (2) @(negedge clk);
    chk("oe_rdn_excl", n_viol, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
